// File: rtl/wide_add_pkg.sv
// Shared types and constants for the wide-operand add sequencer.
package wide_add_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the slice index; never below 1 so the counter always exists.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/wide_add_sequencer.sv
// Sequences an N x 16-bit add through an external combinational 16-bit adder,
// one slice per cycle. Define WIDE_ADD_OVF_EN to add the signed-overflow output out_ovf.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SLICE_W*WORDS-1:0] in_a,
  input  logic [SLICE_W*WORDS-1:0] in_b,
  input  logic                     in_cin,
  output logic [SLICE_W-1:0]       add_a,
  output logic [SLICE_W-1:0]       add_b,
  output logic                     add_cin,
  input  logic [SLICE_W-1:0]       add_sum,
  input  logic                     add_cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SLICE_W*WORDS-1:0] out_sum,
  output logic                     out_cout
`ifdef WIDE_ADD_OVF_EN
  ,
  output logic                     out_ovf
`endif
);

  localparam int W     = SLICE_W * WORDS;
  localparam int IDX_W = clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [W-1:0]         a_q, a_d;
  logic [W-1:0]         b_q, b_d;
  logic                 cin_q, cin_d;
  logic                 carry_q, carry_d;
  logic [W-1:0]         sum_q, sum_d;
  logic                 cout_q, cout_d;
  logic                 valid_q, valid_d;
  logic [SLICE_W-1:0]   add_a_q, add_a_d;
  logic [SLICE_W-1:0]   add_b_q, add_b_d;
  logic                 add_cin_q, add_cin_d;
`ifdef WIDE_ADD_OVF_EN
  logic                 ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = valid_q;
`ifdef WIDE_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cin_d   = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[SLICE_W*idx_q +: SLICE_W] = add_sum;
        carry_d = add_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
`ifdef WIDE_ADD_OVF_EN
          // Carry into the MSB is recovered from the MSB sum bit and its operands.
          ovf_d   = add_a_q[SLICE_W-1] ^ add_b_q[SLICE_W-1] ^ add_sum[SLICE_W-1] ^ add_cout;
`endif
          idx_d   = '0;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    // Adder inputs are registered one slice ahead so they are glitch-free and zero when idle.
    add_a_d   = '0;
    add_b_d   = '0;
    add_cin_d = 1'b0;
    if (state_d == RUN) begin
      add_a_d   = a_d[SLICE_W*idx_d +: SLICE_W];
      add_b_d   = b_d[SLICE_W*idx_d +: SLICE_W];
      add_cin_d = (idx_d == '0) ? cin_d : carry_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      valid_q   <= 1'b0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      valid_q   <= valid_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_cin_q <= add_cin_d;
`ifdef WIDE_ADD_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
    a_q   <= a_d;
    b_q   <= b_d;
    cin_q <= cin_d;
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
`ifdef WIDE_ADD_OVF_EN
  assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer (WORDS=4) with a behavioural 16-bit adder.
module tb_wide_add_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_cin;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic        out_cout;
`ifdef WIDE_ADD_OVF_EN
  logic        out_ovf;
`endif

  int n_checks;
  int n_fail;

  logic [16:0] adder_full;
  assign adder_full = 17'(add_a) + 17'(add_b) + 17'(add_cin);
  assign add_sum    = adder_full[15:0];
  assign add_cout   = adder_full[16];

  wide_add_sequencer #(.WORDS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout)
`ifdef WIDE_ADD_OVF_EN
    ,
    .out_ovf  (out_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits for out_valid; lat is the number of edges taken, -1 on timeout.
  // cin_all is the AND of add_cin over the cycles seen before out_valid.
  task automatic wait_valid(output int lat, output logic cin_all, output logic rdy_any);
    lat     = -1;
    cin_all = 1'b1;
    rdy_any = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cin_all = cin_all & add_cin;
      rdy_any = rdy_any | in_ready;
      tick();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic launch(input logic [63:0] a, input logic [63:0] b, input logic cin);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  int   lat;
  logic cin_all;
  logic rdy_any;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();

    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", out_sum, 64'd0);
    chk("rst_out_cout", 64'(out_cout), 64'd0);
    chk("rst_add_bus", {31'd0, add_cin, add_a, add_b}, 64'd0);
`ifdef WIDE_ADD_OVF_EN
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
`endif
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Small add, latency check
    launch(64'h0000_0000_0000_001F, 64'h0000_0000_0000_000C, 1'b0);
    chk("run_add_a0", 64'(add_a), 64'h1F);
    wait_valid(lat, cin_all, rdy_any);
    chk("small_latency", 64'(lat), 64'd4);
    chk("small_in_ready_busy", 64'(rdy_any), 64'd0);
    chk("small_sum", out_sum, 64'h0000_0000_0000_002B);
    chk("small_cout", 64'(out_cout), 64'd0);
    pop();
    chk("pop_valid_low", 64'(out_valid), 64'd0);
    chk("pop_in_ready", 64'(in_ready), 64'd1);
    chk("idle_add_bus", {31'd0, add_cin, add_a, add_b}, 64'd0);

    // Full carry ripple
    launch(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    wait_valid(lat, cin_all, rdy_any);
    chk("ripple_latency", 64'(lat), 64'd4);
    chk("ripple_cin_all", 64'(cin_all), 64'd1);
    chk("ripple_sum", out_sum, 64'd0);
    chk("ripple_cout", 64'(out_cout), 64'd1);
    pop();

    // Inter-slice carry; out_ready held high while out_valid is low
    out_ready = 1'b1;
    tick();
    chk("early_ready_ignored", 64'(out_valid), 64'd0);
    launch(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    out_ready = 1'b1;
    wait_valid(lat, cin_all, rdy_any);
    chk("slice_latency", 64'(lat), 64'd4);
    chk("slice_sum", out_sum, 64'h0000_0000_0001_0000);
    chk("slice_cout", 64'(out_cout), 64'd0);
    tick();
    chk("slice_popped", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Backpressure with a waiting producer
    launch(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
    in_a     = 64'd5;
    in_b     = 64'd6;
    in_cin   = 1'b0;
    in_valid = 1'b1;
    wait_valid(lat, cin_all, rdy_any);
    chk("bp_latency", 64'(lat), 64'd4);
    chk("bp_no_accept_run", 64'(rdy_any), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_sum_hold", out_sum, 64'h2345_6789_ABCD_F001);
      chk("bp_valid_hold", 64'(out_valid), 64'd1);
      chk("bp_in_ready_done", 64'(in_ready), 64'd0);
      tick();
    end
    chk("bp_cout_hold", 64'(out_cout), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_back_idle", 64'(in_ready), 64'd1);
    chk("bp_valid_drop", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("bp_accepted", 64'(in_ready), 64'd0);
    wait_valid(lat, cin_all, rdy_any);
    chk("bp2_latency", 64'(lat), 64'd4);
    chk("bp2_sum", out_sum, 64'd11);
    pop();

    // Reset during RUN at slice index 2
    launch(64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_sum", out_sum, 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_add_bus", {31'd0, add_cin, add_a, add_b}, 64'd0);
    rdy_any = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rdy_any = rdy_any | out_valid;
      tick();
    end
    chk("abort_no_valid", 64'(rdy_any), 64'd0);
    launch(64'h9249_9249_9249_9249, 64'h9249_9249_9249_9249, 1'b1);
    wait_valid(lat, cin_all, rdy_any);
    chk("post_latency", 64'(lat), 64'd4);
    chk("post_sum", out_sum, 64'h2493_2493_2493_2493);
    chk("post_cout", 64'(out_cout), 64'd1);
    pop();

    // MSB-only carry-out
    launch(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0);
    wait_valid(lat, cin_all, rdy_any);
    chk("msb_sum", out_sum, 64'h1);
    chk("msb_cout", 64'(out_cout), 64'd1);
    pop();

`ifdef WIDE_ADD_OVF_EN
    launch(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    wait_valid(lat, cin_all, rdy_any);
    chk("ovf_sum", out_sum, 64'h8000_0000_0000_0000);
    chk("ovf_flag", 64'(out_ovf), 64'd1);
    chk("ovf_cout", 64'(out_cout), 64'd0);
    pop();
    launch(64'h1, 64'h1, 1'b0);
    wait_valid(lat, cin_all, rdy_any);
    chk("noovf_sum", out_sum, 64'h2);
    chk("noovf_flag", 64'(out_ovf), 64'd0);
    pop();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
